// File: rtl/id_bypass_pkg.sv
// Shared encodings and the scoreboard entry layout for the ID-stage operand bypass.
// Entry fields are sized for the widest supported configuration; narrower users zero-extend.
package id_bypass_pkg;

  localparam int SEL_RF  = 0;
  localparam int SEL_EX  = 1;
  localparam int SEL_MEM = 2;
  localparam int SEL_WB  = 3;

  localparam int AVAIL_EX  = 0;
  localparam int AVAIL_MEM = 1;

  localparam int SB_RD_W = 8;
  localparam int SB_AV_W = 4;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic [SB_AV_W-1:0] avail;
  } sb_entry_t;

endpackage

// File: rtl/bypass_port_sel.sv
// Per-read-port youngest-producer search and operand mux over the in-flight scoreboard.
module bypass_port_sel
  import id_bypass_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 3,
  parameter int SW         = $clog2(NUM_STAGES + 1)
) (
  input  logic [REG_AW-1:0]            src_addr,
  input  logic                         src_used,
  input  logic [DATA_W-1:0]            rf_data,
  input  sb_entry_t [NUM_STAGES-1:0]   sb,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_data,
  output logic [DATA_W-1:0]            opnd,
  output logic [SW-1:0]                sel,
  output logic                         not_ready
);

  logic found;

  // Lowest stage index is the youngest producer, so the first hit wins.
  always_comb begin
    opnd      = rf_data;
    sel       = SW'(SEL_RF);
    not_ready = 1'b0;
    found     = 1'b0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (!found && sb[s].valid && src_used && (src_addr != '0) &&
          (sb[s].rd == SB_RD_W'(src_addr))) begin
        found = 1'b1;
        if (sb[s].avail <= SB_AV_W'(s)) begin
          opnd = stage_data[s*DATA_W +: DATA_W];
          sel  = SW'(s + 1);
        end else begin
          not_ready = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/id_operand_bypass.sv
// ID-stage bypass/interlock: owns the scoreboard of downstream register writes and the stall.
// A stalled ID instruction enters EX as a bubble; flush kills the ID and EX instructions.
module id_operand_bypass
  import id_bypass_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int SW         = $clog2(NUM_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]    id_src_addr,
  input  logic [NUM_SRC-1:0]           id_src_used,
  input  logic [NUM_SRC*DATA_W-1:0]    rf_data,
  input  logic                         id_wen,
  input  logic [REG_AW-1:0]            id_rd,
  input  logic [SW-1:0]                id_avail,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_data,
  input  logic                         pipe_hold,
  input  logic                         flush,
  output logic [NUM_SRC*DATA_W-1:0]    opnd,
  output logic [NUM_SRC*SW-1:0]        fwd_sel,
  output logic                         stall
);

  sb_entry_t [NUM_STAGES-1:0] sb;
  sb_entry_t                  sb_in;
  logic [NUM_SRC-1:0]         port_not_ready;

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_port
    bypass_port_sel #(
      .DATA_W     (DATA_W),
      .REG_AW     (REG_AW),
      .NUM_STAGES (NUM_STAGES),
      .SW         (SW)
    ) u_sel (
      .src_addr   (id_src_addr[p*REG_AW +: REG_AW]),
      .src_used   (id_src_used[p]),
      .rf_data    (rf_data[p*DATA_W +: DATA_W]),
      .sb         (sb),
      .stage_data (stage_data),
      .opnd       (opnd[p*DATA_W +: DATA_W]),
      .sel        (fwd_sel[p*SW +: SW]),
      .not_ready  (port_not_ready[p])
    );
  end

  assign stall = id_valid & (|port_not_ready);

  always_comb begin
    sb_in       = '0;
    sb_in.valid = id_valid & id_wen & ~stall;
    sb_in.rd    = SB_RD_W'(id_rd);
    sb_in.avail = SB_AV_W'(id_avail);
  end

  // Under hold only the ID-side slot can be killed; otherwise flush kills EX and MEM arrivals.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb <= '0;
    end else if (pipe_hold) begin
      if (flush) begin
        sb[0].valid <= 1'b0;
      end
    end else begin
      for (int s = NUM_STAGES - 1; s > 0; s--) begin
        sb[s] <= sb[s-1];
      end
      sb[0] <= sb_in;
      if (flush) begin
        for (int s = 0; s < NUM_STAGES; s++) begin
          if (s < 2) begin
            sb[s].valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_id_operand_bypass.sv
// Directed bench for id_operand_bypass: forwarding priority, load-use interlock, flush, hold, reset.
module tb_id_operand_bypass;
  import id_bypass_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int NSRC   = 2;
  localparam int NSTG   = 3;
  localparam int SW     = 2;

  localparam logic [31:0] RF0 = 32'hF000_0000;
  localparam logic [31:0] RF1 = 32'hF111_1111;

  logic                     clk;
  logic                     rst_n;
  logic                     id_valid;
  logic [NSRC*REG_AW-1:0]   id_src_addr;
  logic [NSRC-1:0]          id_src_used;
  logic [NSRC*DATA_W-1:0]   rf_data;
  logic                     id_wen;
  logic [REG_AW-1:0]        id_rd;
  logic [SW-1:0]            id_avail;
  logic [NSTG*DATA_W-1:0]   stage_data;
  logic                     pipe_hold;
  logic                     flush;
  logic [NSRC*DATA_W-1:0]   opnd;
  logic [NSRC*SW-1:0]       fwd_sel;
  logic                     stall;

  int testsRun  = 0;
  int failCount = 0;

  id_operand_bypass #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NSRC), .NUM_STAGES(NSTG), .SW(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .rf_data(rf_data), .id_wen(id_wen), .id_rd(id_rd),
    .id_avail(id_avail), .stage_data(stage_data), .pipe_hold(pipe_hold), .flush(flush),
    .opnd(opnd), .fwd_sel(fwd_sel), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] o0, input logic [31:0] o1,
                             input int s0, input int s1, input logic st);
    #1;
    checkField({tag, ".opnd0"}, opnd[31:0], o0);
    checkField({tag, ".opnd1"}, opnd[63:32], o1);
    checkField({tag, ".sel0"}, 32'(fwd_sel[1:0]), 32'(s0));
    checkField({tag, ".sel1"}, 32'(fwd_sel[3:2]), 32'(s1));
    checkField({tag, ".stall"}, 32'(stall), 32'(st));
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] a0, input logic [4:0] a1,
                               input logic [1:0] used, input logic wen, input logic [4:0] rd,
                               input int avail);
    id_valid    = v;
    id_src_addr = {a1, a0};
    id_src_used = used;
    id_wen      = wen;
    id_rd       = rd;
    id_avail    = SW'(avail);
  endtask

  task automatic setStages(input logic [31:0] ex, input logic [31:0] mem, input logic [31:0] wb);
    stage_data = {wb, mem, ex};
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    pipe_hold = 1'b0;
    flush     = 1'b0;
    rf_data   = {RF1, RF0};
    setStages(32'h11, 32'h22, 32'h33);
    applyStimulus(1'b1, 5'd8, 5'd8, 2'b11, 1'b0, 5'd0, AVAIL_EX);
    #3;
    checkOutput("reset", RF0, RF1, SEL_RF, SEL_RF, 1'b0);
    #4 rst_n = 1'b1;

    // ALU writes r8, dependent reads it from EX next cycle
    nextCycle();
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd8, AVAIL_EX);
    checkOutput("empty", RF0, RF1, SEL_RF, SEL_RF, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd8, 5'd3, 2'b11, 1'b0, 5'd0, AVAIL_EX);
    checkOutput("alu_ex", 32'h11, RF1, SEL_EX, SEL_RF, 1'b0);

    // load r9 issued while r8 sits in MEM
    nextCycle();
    applyStimulus(1'b1, 5'd8, 5'd0, 2'b01, 1'b1, 5'd9, AVAIL_MEM);
    checkOutput("r8_mem", 32'h22, RF1, SEL_MEM, SEL_RF, 1'b0);

    // load-use on port 1: one stall cycle, r8 forwarded from WB on port 0
    nextCycle();
    applyStimulus(1'b1, 5'd8, 5'd9, 2'b11, 1'b1, 5'd12, AVAIL_EX);
    #1;
    checkField("lu.stall", 32'(stall), 32'd1);
    checkField("lu.sel0", 32'(fwd_sel[1:0]), 32'(SEL_WB));
    checkField("lu.opnd0", opnd[31:0], 32'h33);
    nextCycle();
    setStages(32'h11, 32'h99, 32'h33);
    checkOutput("lu_mem", RF0, 32'h99, SEL_RF, SEL_MEM, 1'b0);

    // r10 written twice; youngest (EX) wins, then ages out to register file
    nextCycle();
    applyStimulus(1'b1, 5'd9, 5'd9, 2'b00, 1'b1, 5'd10, AVAIL_EX);
    checkOutput("unused", RF0, RF1, SEL_RF, SEL_RF, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd13, AVAIL_EX);
    nextCycle();
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd10, AVAIL_EX);
    nextCycle();
    setStages(32'hAA, 32'h22, 32'hBB);
    applyStimulus(1'b1, 5'd10, 5'd0, 2'b01, 1'b0, 5'd0, AVAIL_EX);
    checkOutput("r10_young", 32'hAA, RF1, SEL_EX, SEL_RF, 1'b0);
    nextCycle();
    checkOutput("r10_mem", 32'h22, RF1, SEL_MEM, SEL_RF, 1'b0);
    nextCycle();
    checkOutput("r10_wb", 32'hBB, RF1, SEL_WB, SEL_RF, 1'b0);
    nextCycle();
    checkOutput("r10_rf", RF0, RF1, SEL_RF, SEL_RF, 1'b0);

    // r0 is never forwarded; unused port never stalls
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd0, AVAIL_EX);
    checkOutput("r0_a", RF0, RF1, SEL_RF, SEL_RF, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd9, AVAIL_MEM);
    checkOutput("r0_b", RF0, RF1, SEL_RF, SEL_RF, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd0, 5'd9, 2'b01, 1'b1, 5'd15, AVAIL_EX);
    checkOutput("unused_ld", RF0, RF1, SEL_RF, SEL_RF, 1'b0);

    // flush with load r11 in EX and a dependent in ID
    nextCycle();
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd11, AVAIL_MEM);
    nextCycle();
    setStages(32'h11, 32'h55, 32'h66);
    applyStimulus(1'b1, 5'd11, 5'd15, 2'b11, 1'b1, 5'd14, AVAIL_EX);
    #1;
    checkField("fl_pre.stall", 32'(stall), 32'd1);
    checkField("fl_pre.sel1", 32'(fwd_sel[3:2]), 32'(SEL_MEM));
    flush = 1'b1;
    nextCycle();
    flush = 1'b0;
    checkOutput("fl_post", RF0, 32'h66, SEL_RF, SEL_WB, 1'b0);

    // hold for three edges: ID write must not enter and WB entry must stay
    pipe_hold = 1'b1;
    applyStimulus(1'b1, 5'd16, 5'd15, 2'b11, 1'b1, 5'd16, AVAIL_EX);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("hold", RF0, 32'h66, SEL_RF, SEL_WB, 1'b0);
    end
    pipe_hold = 1'b0;
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd20, AVAIL_MEM);

    // async reset in the middle of a load-use stall
    nextCycle();
    applyStimulus(1'b1, 5'd20, 5'd0, 2'b01, 1'b0, 5'd0, AVAIL_EX);
    #1;
    checkField("rst_pre.stall", 32'(stall), 32'd1);
    #1 rst_n = 1'b0;
    checkOutput("rst_mid", RF0, RF1, SEL_RF, SEL_RF, 1'b0);
    #2 rst_n = 1'b1;
    nextCycle();
    checkOutput("rst_after", RF0, RF1, SEL_RF, SEL_RF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/id_operand_bypass.md
# id_operand_bypass

Parametrised ID-stage operand bypass and interlock unit for the MIPS pipeline, the successor to the single-operand rt forwarding mux. It keeps its own registered scoreboard of in-flight register writes across NUM_STAGES downstream stages, and for each of NUM_SRC read ports selects the youngest matching producer's stage data, falling back to the register file when there is no match. When the youngest producer's result is not yet available (load-use, multi-stage results), it raises a stall and inserts a bubble.

## Interface
Parameters:
- DATA_W, 32, operand width
- REG_AW, 5, register address width
- NUM_SRC, 2, read ports (rs, rt)
- NUM_STAGES, 3, tracked stages after ID: 0=EX, 1=MEM, 2=WB
- SW, $clog2(NUM_STAGES+1), width of stage index / select fields

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  instruction present in ID
- id_src_addr  in  NUM_SRC*REG_AW  source register per port
- id_src_used  in  NUM_SRC  port is actually read by the instruction
- rf_data  in  NUM_SRC*DATA_W  register file read data per port
- id_wen  in  1  ID instruction writes a register
- id_rd  in  REG_AW  destination register of ID instruction
- id_avail  in  SW  first stage index whose stage_data carries the result (0 = ALU or PC+4 link, 1 = load/mult)
- stage_data  in  NUM_STAGES*DATA_W  result bus of each stage (EX result, MEM mux output, WB mux output)
- pipe_hold  in  1  downstream freeze; scoreboard does not move
- flush  in  1  kill instructions in ID and EX
- opnd  out  NUM_SRC*DATA_W  forwarded operand per port
- fwd_sel  out  NUM_SRC*SW  0 = register file, s+1 = stage s
- stall  out  1  hold ID/IF, bubble into EX

## Operation
- Scoreboard: NUM_STAGES entries {valid, rd, avail}. Entry s describes the instruction currently in stage s.
- Match on port p: entry valid, rd == src_addr[p], rd != 0, id_src_used[p]. Only the youngest match (lowest s) counts; older matches are ignored.
- Youngest match at s with avail <= s: opnd[p] = stage_data[s], fwd_sel[p] = s+1.
- Youngest match at s with avail > s: port not ready.
- No match: opnd[p] = rf_data[p], fwd_sel[p] = 0.
- stall = id_valid & (any port not ready). A port is never stalled by register 0. Operands are computed even when id_valid = 0, but stall stays 0.
- Register file is written on the clock edge at which the WB entry retires. Reads after that edge use rf_data, and no write-through is required.

## Timing
- Reset (async assert): all entries invalid. Outputs follow immediately: stall = 0, fwd_sel = 0, opnd = rf_data.
- opnd, fwd_sel and stall are combinational from the scoreboard and inputs. There is zero latency from an entry to its forwarding.
- Each edge, with pipe_hold = 0 and flush = 0: entries shift s -> s+1 and the last entry retires. Entry 0 loads {id_valid & id_wen & !stall, id_rd, id_avail}, so a stall inserts a bubble.
- pipe_hold = 1: no entry moves, and stall still reflects the current state.
- flush = 1: at the next edge, entry 0 and entry 1 are invalid and the ID instruction is not inserted. Entries 2 and above shift normally. Under a simultaneous pipe_hold, only entry 0 is invalidated and all others hold.
- A load (avail = 1) followed directly by a dependent instruction gives exactly one stall cycle, after which the operand comes from MEM.
- Reset deasserted mid-stream: the scoreboard starts empty, and no stale forwarding occurs.

## Structure
- Package id_bypass_pkg holds:
  - the select encodings (SEL_RF = 0, SEL_EX = 1, SEL_MEM = 2, SEL_WB = 3)
  - the avail constants (AVAIL_EX = 0, AVAIL_MEM = 1)
  - the scoreboard entry struct
- Sub-module bypass_port_sel holds the per-port priority compare and data mux. It is instantiated NUM_SRC times. The top level holds the scoreboard registers and the stall logic.

## Test plan
- ALU r8 = 0x11 then dependent reading r8 on port 0: fwd_sel = 1, opnd = EX data 0x11, stall = 0.
- Load r9 (avail = 1) then immediate use of r9 on port 1: one cycle with stall = 1 and an EX bubble. Next cycle fwd_sel = 2 and opnd = MEM data.
- r10 is written by both EX (0xAA) and WB (0xBB) entries: the port gets 0xAA. Three cycles after its last write, it gets rf_data.
- Writes to r0 and reads of r0, and a load to r9 with id_src_used = 0: no forwarding, stall = 0, opnd = rf_data.
- flush with a load in EX and a dependent instruction in ID: the next cycle has entries 0 and 1 invalid and stall = 0. With pipe_hold = 1 for 3 cycles, the scoreboard is unchanged.
- Async reset asserted mid-stall: stall drops immediately and all fwd_sel = 0.
